// File: rtl/id_exe_stage_reg_pkg.sv
// id_exe_stage_reg_pkg: shared types and encodings for the ID/EXE stage register
package id_exe_stage_reg_pkg;
  localparam int REG_W = 4;
  localparam int CMD_W = 4;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  typedef struct packed {
    logic             wb_en;
    logic             mem_read;
    logic             mem_write;
    logic             b;
    logic             s;
    logic             imm;
    logic [CMD_W-1:0] exe_cmd;
  } ctrl_t;
endpackage

// File: rtl/id_exe_stage_reg_fwd_select.sv
// fwd_select: forwarding select for one source operand; the nearer producer wins
module fwd_select
  import id_exe_stage_reg_pkg::*;
#(
  parameter int W = REG_W
) (
  input  logic [W-1:0] src,
  input  logic         valid,
  input  logic         forward_en,
  input  logic [W-1:0] exe_dest,
  input  logic         exe_wb_en,
  input  logic [W-1:0] mem_dest,
  input  logic         mem_wb_en,
  output logic [1:0]   sel
);
  always_comb
    sel = !(forward_en && valid)           ? FWD_RF  :
          (exe_wb_en && src == exe_dest)   ? FWD_MEM :
          (mem_wb_en && src == mem_dest)   ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID/EXE pipeline register with bubble insertion, freeze and forwarding selects
module id_exe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              hazard,
  input  logic              forward_en,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_b,
  input  logic              id_s,
  input  logic              id_imm,
  input  logic [3:0]        id_exe_cmd,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_val_rn,
  input  logic [DATA_W-1:0] id_val_rm,
  input  logic [11:0]       id_shift_operand,
  input  logic [23:0]       id_signed_imm_24,
  input  logic [REG_W-1:0]  id_dest,
  input  logic [REG_W-1:0]  id_src1,
  input  logic [REG_W-1:0]  id_src2,
  input  logic              id_two_src,
  input  logic [3:0]        id_status,
  input  logic [REG_W-1:0]  mem_dest,
  input  logic              mem_wb_en,
  input  logic              cnt_clr,
  output logic              exe_wb_en,
  output logic              exe_mem_read,
  output logic              exe_mem_write,
  output logic              exe_b,
  output logic              exe_s,
  output logic              exe_imm,
  output logic [3:0]        exe_exe_cmd,
  output logic [DATA_W-1:0] exe_pc,
  output logic [DATA_W-1:0] exe_val_rn,
  output logic [DATA_W-1:0] exe_val_rm,
  output logic [11:0]       exe_shift_operand,
  output logic [23:0]       exe_signed_imm_24,
  output logic [REG_W-1:0]  exe_dest,
  output logic [3:0]        exe_status,
  output logic [1:0]        exe_sel_src1,
  output logic [1:0]        exe_sel_src2,
  output logic [CNT_W-1:0]  bubble_cnt
);
  import id_exe_stage_reg_pkg::*;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl_d;
  logic [1:0] sel1_d;
  logic [1:0] sel2_d;
  logic       bubble;
  assign ctrl_d = '{wb_en: id_wb_en, mem_read: id_mem_read, mem_write: id_mem_write,
                    b: id_b, s: id_s, imm: id_imm, exe_cmd: id_exe_cmd};
  assign {exe_wb_en, exe_mem_read, exe_mem_write, exe_b, exe_s, exe_imm, exe_exe_cmd} = ctrl_q;
  assign bubble = flush || hazard;
  // Selects compare against the current stage outputs, i.e. the producer heading to MEM
  fwd_select #(.W(REG_W)) u_fwd1 (
    .src(id_src1), .valid(1'b1), .forward_en(forward_en),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .sel(sel1_d)
  );
  fwd_select #(.W(REG_W)) u_fwd2 (
    .src(id_src2), .valid(id_two_src), .forward_en(forward_en),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .sel(sel2_d)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q            <= '0;
      exe_pc            <= '0;
      exe_val_rn        <= '0;
      exe_val_rm        <= '0;
      exe_shift_operand <= '0;
      exe_signed_imm_24 <= '0;
      exe_dest          <= '0;
      exe_status        <= '0;
      exe_sel_src1      <= FWD_RF;
      exe_sel_src2      <= FWD_RF;
      bubble_cnt        <= '0;
    end else if (!freeze) begin
      ctrl_q            <= bubble ? '0 : ctrl_d;
      exe_pc            <= bubble ? '0 : id_pc;
      exe_val_rn        <= bubble ? '0 : id_val_rn;
      exe_val_rm        <= bubble ? '0 : id_val_rm;
      exe_shift_operand <= bubble ? '0 : id_shift_operand;
      exe_signed_imm_24 <= bubble ? '0 : id_signed_imm_24;
      exe_dest          <= bubble ? '0 : id_dest;
      exe_status        <= bubble ? '0 : id_status;
      exe_sel_src1      <= bubble ? FWD_RF : sel1_d;
      exe_sel_src2      <= bubble ? FWD_RF : sel2_d;
      bubble_cnt        <= cnt_clr ? CNT_W'(bubble) :
                           (bubble && !(&bubble_cnt)) ? bubble_cnt + CNT_W'(1) : bubble_cnt;
    end
  end
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// tb_id_exe_stage_reg: table-driven check of load, forwarding, bubbles, freeze, counter and reset
module tb_id_exe_stage_reg;
  logic clk = 1'b0;
  logic rst_n, freeze, flush, hazard, forward_en;
  logic id_wb_en, id_mem_read, id_mem_write, id_b, id_s, id_imm;
  logic [3:0] id_exe_cmd, id_status;
  logic [31:0] id_pc, id_val_rn, id_val_rm;
  logic [11:0] id_shift_operand;
  logic [23:0] id_signed_imm_24;
  logic [3:0] id_dest, id_src1, id_src2, mem_dest;
  logic id_two_src, mem_wb_en, cnt_clr;
  logic exe_wb_en, exe_mem_read, exe_mem_write, exe_b, exe_s, exe_imm;
  logic [3:0] exe_exe_cmd, exe_status, exe_dest;
  logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
  logic [11:0] exe_shift_operand;
  logic [23:0] exe_signed_imm_24;
  logic [1:0] exe_sel_src1, exe_sel_src2;
  logic [3:0] bubble_cnt;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  id_exe_stage_reg #(.DATA_W(32), .REG_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .hazard(hazard),
    .forward_en(forward_en), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_b(id_b), .id_s(id_s), .id_imm(id_imm),
    .id_exe_cmd(id_exe_cmd), .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm),
    .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
    .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_status(id_status), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .cnt_clr(cnt_clr),
    .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .exe_mem_write(exe_mem_write),
    .exe_b(exe_b), .exe_s(exe_s), .exe_imm(exe_imm), .exe_exe_cmd(exe_exe_cmd),
    .exe_pc(exe_pc), .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm),
    .exe_shift_operand(exe_shift_operand), .exe_signed_imm_24(exe_signed_imm_24),
    .exe_dest(exe_dest), .exe_status(exe_status), .exe_sel_src1(exe_sel_src1),
    .exe_sel_src2(exe_sel_src2), .bubble_cnt(bubble_cnt)
  );
  typedef struct {
    logic frz, fl, hz, fe, wb, mr, two, mwb, clr;
    logic [3:0] dest, s1, s2, mdest;
    logic [31:0] val;
    logic e_wb, e_mr;
    logic [3:0] e_dest;
    logic [31:0] e_val;
    logic [1:0] e_s1, e_s2;
    logic [3:0] e_cnt;
  } vec_t;
  vec_t vecs [18];
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  function automatic logic [255:0] all_out();
    return {exe_wb_en, exe_mem_read, exe_mem_write, exe_b, exe_s, exe_imm, exe_exe_cmd,
            exe_pc, exe_val_rn, exe_val_rm, exe_shift_operand, exe_signed_imm_24,
            exe_dest, exe_status, exe_sel_src1, exe_sel_src2, bubble_cnt};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    vecs[0]  = '{0,0,0,1,1,0,0,0,0, 3,0,0,0, 32'h1234, 1,0,3,32'h1234,0,0,0};
    vecs[1]  = '{0,0,0,1,1,0,0,0,0, 2,3,0,0, 32'h11,   1,0,2,32'h11,  1,0,0};
    vecs[2]  = '{0,0,0,1,1,0,0,1,0, 2,2,0,2, 32'h22,   1,0,2,32'h22,  1,0,0};
    vecs[3]  = '{0,0,0,1,0,0,0,1,0, 2,2,0,2, 32'h33,   0,0,2,32'h33,  1,0,0};
    vecs[4]  = '{0,0,0,1,0,0,0,1,0, 2,2,0,2, 32'h44,   0,0,2,32'h44,  2,0,0};
    vecs[5]  = '{0,0,0,0,0,0,0,1,0, 2,2,0,2, 32'h55,   0,0,2,32'h55,  0,0,0};
    vecs[6]  = '{0,0,0,1,1,0,0,0,0, 5,0,0,0, 32'h66,   1,0,5,32'h66,  0,0,0};
    vecs[7]  = '{0,0,0,1,1,0,0,0,0, 5,0,5,0, 32'h77,   1,0,5,32'h77,  0,0,0};
    vecs[8]  = '{0,0,0,1,1,0,1,0,0, 5,5,5,0, 32'h88,   1,0,5,32'h88,  1,1,0};
    vecs[9]  = '{0,0,1,1,1,1,0,0,0, 7,0,0,0, 32'h99,   0,0,0,32'h0,   0,0,1};
    vecs[10] = '{0,0,1,1,1,1,0,0,0, 7,0,0,0, 32'h99,   0,0,0,32'h0,   0,0,2};
    vecs[11] = '{0,0,0,1,1,1,0,0,0, 7,0,0,0, 32'hABCD, 1,1,7,32'hABCD,0,0,2};
    vecs[12] = '{1,1,0,1,0,0,0,0,0, 9,7,7,0, 32'hEEEE, 1,1,7,32'hABCD,0,0,2};
    vecs[13] = '{1,0,0,1,0,0,0,0,1, 9,0,0,0, 32'hEEEE, 1,1,7,32'hABCD,0,0,2};
    vecs[14] = '{0,0,0,1,0,0,0,0,1, 1,0,0,0, 32'h1,    0,0,1,32'h1,   0,0,0};
    vecs[15] = '{0,1,0,1,1,0,0,0,1, 4,0,0,0, 32'h5,    0,0,0,32'h0,   0,0,1};
    vecs[16] = '{0,0,0,1,1,0,0,1,0, 15,15,0,15, 32'hF, 1,0,15,32'hF,  2,0,1};
    vecs[17] = '{0,0,0,1,1,0,1,1,0, 15,15,15,15,32'h10,1,0,15,32'h10, 1,1,1};
    rst_n = 1'b0; freeze = 0; flush = 0; hazard = 0; forward_en = 0;
    id_wb_en = 0; id_mem_read = 0; id_mem_write = 0; id_b = 0; id_s = 0; id_imm = 0;
    id_exe_cmd = 0; id_status = 0; id_pc = 0; id_val_rn = 0; id_val_rm = 0;
    id_shift_operand = 0; id_signed_imm_24 = 0; id_dest = 0; id_src1 = 0; id_src2 = 0;
    id_two_src = 0; mem_dest = 0; mem_wb_en = 0; cnt_clr = 0;
    #12;
    chk("reset_state", all_out(), '0);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      freeze = vecs[i].frz; flush = vecs[i].fl; hazard = vecs[i].hz; forward_en = vecs[i].fe;
      id_wb_en = vecs[i].wb; id_mem_read = vecs[i].mr; id_two_src = vecs[i].two;
      mem_wb_en = vecs[i].mwb; cnt_clr = vecs[i].clr; id_dest = vecs[i].dest;
      id_src1 = vecs[i].s1; id_src2 = vecs[i].s2; mem_dest = vecs[i].mdest; id_val_rn = vecs[i].val;
      tick();
      chk($sformatf("v%0d_wb_en", i), exe_wb_en, vecs[i].e_wb);
      chk($sformatf("v%0d_mem_read", i), exe_mem_read, vecs[i].e_mr);
      chk($sformatf("v%0d_dest", i), exe_dest, vecs[i].e_dest);
      chk($sformatf("v%0d_val_rn", i), exe_val_rn, vecs[i].e_val);
      chk($sformatf("v%0d_sel_src1", i), exe_sel_src1, vecs[i].e_s1);
      chk($sformatf("v%0d_sel_src2", i), exe_sel_src2, vecs[i].e_s2);
      chk($sformatf("v%0d_bubble_cnt", i), bubble_cnt, vecs[i].e_cnt);
    end
    // Counter saturation: count is 1 entering the run of flushes
    freeze = 0; hazard = 0; cnt_clr = 0; flush = 1;
    begin
      logic [3:0] exp_cnt;
      exp_cnt = 4'd1;
      for (int i = 0; i < 17; i++) begin
        tick();
        exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
        chk($sformatf("sat_cnt_%0d", i), bubble_cnt, exp_cnt);
      end
    end
    chk("sat_wb_en", exe_wb_en, 1'b0);
    flush = 0; cnt_clr = 1;
    tick();
    chk("cnt_clr", bubble_cnt, 4'h0);
    cnt_clr = 0;
    // Full-field load
    forward_en = 0; id_wb_en = 1; id_mem_read = 0; id_mem_write = 1; id_b = 1; id_s = 0; id_imm = 1;
    id_exe_cmd = 4'hA; id_pc = 32'h100; id_val_rn = 32'hDEAD0001; id_val_rm = 32'hBEEF0002;
    id_shift_operand = 12'h5A5; id_signed_imm_24 = 24'hC0FFEE; id_dest = 6; id_status = 4'h9;
    tick();
    chk("full_ctrl", {exe_wb_en, exe_mem_read, exe_mem_write, exe_b, exe_s, exe_imm, exe_exe_cmd},
        {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hA});
    chk("full_pc", exe_pc, 32'h100);
    chk("full_val_rm", exe_val_rm, 32'hBEEF0002);
    chk("full_shift", exe_shift_operand, 12'h5A5);
    chk("full_simm", exe_signed_imm_24, 24'hC0FFEE);
    chk("full_dest", exe_dest, 4'd6);
    chk("full_status", exe_status, 4'h9);
    // Asynchronous reset while frozen, mid-cycle
    freeze = 1;
    #3;
    rst_n = 0;
    #1;
    chk("async_reset", all_out(), '0);
    #3;
    rst_n = 1; freeze = 0;
    tick();
    chk("post_reset_load_dest", exe_dest, 4'd6);
    chk("post_reset_cnt", bubble_cnt, 4'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- ID/EXE pipeline register for the 5-stage core.
- Captures the decoded instruction each cycle. On a hazard or branch flush it inserts a bubble; on a global freeze it holds.
- Registers the EXE-side forwarding selects for src1/src2 and counts bubble cycles.
- Its exe_dest, exe_wb_en and exe_mem_read outputs are the EXE-stage view consumed by the hazard detection unit.

Parameters:
DATA_W, 32, datapath width (PC, Rn/Rm values)
REG_W, 4, register index width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
freeze  in  1  hold all state (memory wait)
flush  in  1  branch taken; insert bubble
hazard  in  1  stall request from hazard detection; insert bubble
forward_en  in  1  forwarding enabled
id_wb_en, id_mem_read, id_mem_write, id_b, id_s, id_imm  in  1 each  decoded control bits
id_exe_cmd  in  4  ALU command
id_pc, id_val_rn, id_val_rm  in  DATA_W each  PC+4 and register file reads
id_shift_operand  in  12  shifter operand
id_signed_imm_24  in  24  branch offset
id_dest, id_src1, id_src2  in  REG_W each  register indices
id_two_src  in  1  src2 is valid
id_status  in  4  NZCV flags
mem_dest  in  REG_W  destination held in EXE/MEM register
mem_wb_en  in  1  writeback enable held in EXE/MEM register
cnt_clr  in  1  synchronous clear of bubble counter
exe_* (wb_en, mem_read, mem_write, b, s, imm, exe_cmd, pc, val_rn, val_rm, shift_operand, signed_imm_24, dest, status)  out  same widths  registered stage outputs
exe_sel_src1, exe_sel_src2  out  2 each  forwarding select: 00 = register file, 01 = MEM-stage result, 10 = WB-stage result
bubble_cnt  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Reset: all outputs are 0, asynchronously when rst_n is low; release is synchronous to clk.
- Per-edge priority: freeze > flush > hazard > load.
- freeze: every register holds, including bubble_cnt. cnt_clr is ignored while frozen.
- flush or hazard (not frozen): bubble. All exe_* fields and selects load 0, so wb_en, mem_read, mem_write, b and s are all 0. bubble_cnt increments by 1 and saturates at all-ones. One bubble per asserted cycle.
- load: every exe_* field takes its id_* value, 1-cycle latency.
- Forwarding selects are computed at load time against the current outputs:
  - The instruction now in EXE (exe_dest, exe_wb_en) moves to MEM next cycle.
  - The instruction in the EXE/MEM register (mem_dest, mem_wb_en) moves to WB next cycle.
- exe_sel_src1:
  - 01 if forward_en, exe_wb_en and id_src1 == exe_dest.
  - Else 10 if forward_en, mem_wb_en and id_src1 == mem_dest.
  - Else 00.
- exe_sel_src2: same rule applied to id_src2, additionally gated by id_two_src.
- The nearer producer (01) always wins over 10.
- forward_en = 0 forces both selects to 00.
- cnt_clr (not frozen) resets bubble_cnt to 0; a bubble in the same cycle leaves the count at 1.
- Register index 15 (PC) gets no special case; matching follows the rules above.
- A load-use case (exe_mem_read with a match) is stalled by hazard detection, so a select of 01 against a load is never consumed.
- Reset while frozen or mid-bubble: reset dominates and the stage restarts empty.

Decomposition:
- Shared package holds:
  - forwarding select encodings FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10;
  - REG_W and the exe_cmd width;
  - a control-bundle typedef {wb_en, mem_read, mem_write, b, s, imm, exe_cmd}.
- One sub-module, fwd_select, is natural: combinational select for one source (src, valid, two compare pairs, forward_en), instantiated twice.

Test Plan:
- Reset: rst_n low mid-cycle with outputs loaded -> all exe_* = 0, selects 00, bubble_cnt 0 immediately.
- Load: id_dest=3, id_wb_en=1, id_val_rn=32'h1234 -> next edge exe_dest=3, exe_wb_en=1, exe_val_rn=32'h1234.
- Forward priority:
  - exe_dest=2, exe_wb_en=1; mem_dest=2, mem_wb_en=1; id_src1=2, forward_en=1 -> exe_sel_src1=01.
  - Repeat with exe_wb_en=0 -> 10.
  - Repeat with forward_en=0 -> 00.
- src2 gating: id_src2=5, exe_dest=5, exe_wb_en=1, id_two_src=0 -> exe_sel_src2=00; id_two_src=1 -> 01.
- Bubble/freeze:
  - hazard=1 for 2 cycles -> exe_wb_en=0 and exe_mem_read=0 both cycles, bubble_cnt=2.
  - freeze=1 together with flush=1 -> all outputs and bubble_cnt unchanged.
- Counter saturation: CNT_W=4, 17 consecutive flush cycles -> bubble_cnt stays 4'hF. Then cnt_clr=1 -> 0.
